booth_wallace_mul_pipe: RTL and testbench
=========================================

Name: booth_wallace_mul_pipe

Overview:
- Parametrised, pipelined successor to the 32-bit combinational radix-8 Booth / Wallace-tree multiplier.
- Width is generic, signed or unsigned mode is selected per operand pair, and results carry a tag.
- The datapath has 3 registered stages with a valid/ready handshake and full backpressure support.
- Sits between an issue stage and a result writeback in the arithmetic units.

Parameters:
- WIDTH, 32: operand width in bits. Legal range is 8..64. Any integer is allowed, with no multiple-of-3 restriction.
- TAG_W, 4: width of the transaction tag carried alongside the operands.
- PP_N, (WIDTH+3)/3 (integer division, i.e. floor): number of radix-8 partial products. This is a derived localparam and must not be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands a, b, is_signed and in_tag are valid this cycle.
- in_ready  out  1  block accepts the operands this cycle.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier; this operand is Booth-recoded.
- is_signed  in  1  1: a and b are two's complement. 0: a and b are unsigned.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  out, out_tag and out_signed are valid.
- out_ready  in  1  consumer accepts the result.
- out  out  2*WIDTH  product a*b in the selected mode.
- out_tag  out  TAG_W  tag of the transaction.
- out_signed  out  1  is_signed of the transaction.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All stage valid bits clear, so out_valid=0.
  - out, out_tag and out_signed are 0.
  - Data registers need not be reset, but out must read 0 until the first result.
  - in_ready is 0 while rst_n=0 and equals 1 on the first cycle after release.
- Handshake:
  - A transfer occurs when in_valid && in_ready (input side) or out_valid && out_ready (output side).
  - Inputs are sampled only on the transfer edge.
  - Once out_valid is high, out, out_tag and out_signed are held stable until out_ready.
- Stall rule (global enable):
  - en = !out_valid || out_ready.
  - in_ready = en.
  - All three stages advance together when en=1 and hold when en=0. Bubbles are not collapsed.
- Latency: an operand accepted at edge N produces out_valid=1 after edge N+3.
- Throughput: 1 result per cycle while out_ready=1.
- Operand extension:
  - a is extended to WIDTH+2 bits: sign-extended if is_signed, zero-extended otherwise.
  - b is extended to 3*PP_N+1 bits, with an implicit b[-1]=0, using the same sign/zero rule.
  - Unsigned mode therefore needs no correction term.
- S1 (encode):
  - Overlapping 4-bit groups {b[3i+2:3i], b[3i-1]}, for i = 0..PP_N-1, are recoded to digits in {-4..+4}.
  - 3a is precomputed with one adder of width WIDTH+2.
  - S1 registers the extended a, 3a, the digit vector, the mode and the tag.
- S2 (reduce):
  - Generates PP_N partial products, each 2*WIDTH bits, shifted left by 3i. Negative digits use the inverted multiple plus a +1 injected at bit 3i.
  - Reduces the partial products with a 3:2 carry-save (Wallace) tree to a sum and carry pair, which S2 registers.
  - All arithmetic is modulo 2^(2*WIDTH).
- S3 (resolve): a single carry-propagate add of sum and carry, truncated to 2*WIDTH bits, is registered to out.
- Correctness: out must equal the full-precision product in the selected mode for every operand pair, including:
  - 0,
  - the most negative value, e.g. 0x80000000 signed,
  - all-ones operands,
  - WIDTH not divisible by 3.
- Simultaneous events: an output pop and an input accept in the same cycle are legal; the pipeline shifts and no result is lost or duplicated.
- Backpressure: when out_valid=1 and out_ready=0, in_ready=0. No input is accepted, and no stage register changes.
- Reset mid-operation: in-flight transactions are discarded and produce no output after reset release.
- No internal state machine beyond the 3 stage valid bits; stage-valid propagation is the only control.

Test Plan:
- Unsigned, WIDTH=32: a=0xFFFFFFFF, b=0xFFFFFFFF, is_signed=0, tag=5 -> 3 cycles later out=0xFFFFFFFE00000001, out_tag=5, out_signed=0.
- Signed, WIDTH=32:
  - a=0x80000000, b=0x80000000 -> out=0x4000000000000000.
  - a=0xFFFFFFFF, b=0x00000003 -> out=0xFFFFFFFFFFFFFFFD.
- Streaming: 4 back-to-back transfers with out_ready=1 and tags 0..3 -> out_valid high for 4 consecutive cycles starting at acceptance+3, tags in order 0,1,2,3.
- Backpressure: out_ready=0 for 5 cycles while the pipe holds 3 results -> in_ready=0, out held stable; raising out_ready drains exactly 3 results in order.
- Reset: assert rst_n=0 with 2 transactions in flight -> out_valid=0 and out=0 immediately; no result appears after release; in_ready=1 on the first cycle after release.
- Random plus generic width: WIDTH=32 with 1000 random transactions, then WIDTH=16 and WIDTH=13, random mode, random out_ready toggling -> every out equals the scoreboard product and the count of results equals the count of accepted inputs.

Source files
------------

// File: rtl/booth_wallace_mul_pipe.sv
// Pipelined radix-8 Booth / Wallace multiplier, generic width.
// Three stages (encode, reduce, resolve) with a valid/ready handshake.
module booth_wallace_mul_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_signed
);

   localparam int PP_N = (WIDTH + 3) / 3;
   localparam int P2   = 2 * WIDTH;
   localparam int BX   = 3 * PP_N + 1;
   localparam int ROWS = PP_N + 1;

   logic                  en;
   logic                  v1, v2, v3;
   logic [WIDTH+1:0]      a_ext, a3;
   logic [WIDTH+1:0]      s1_a, s1_a3;
   logic [BX-1:0]         bx;
   logic [PP_N-1:0][3:0]  dig, s1_dig;
   logic                  s1_sgn, s2_sgn;
   logic [TAG_W-1:0]      s1_tag, s2_tag;
   logic [P2-1:0]         ax, a3x, cor;
   logic [ROWS-1:0][P2-1:0] pp, row, nxt;
   logic [P2-1:0]         sum, car;
   logic [P2-1:0]         s2_sum, s2_car;
   int                    n, g;

   assign en        = !v3 || out_ready;
   assign in_ready  = rst_n && en;
   assign out_valid = v3;

   // S1: operand extension, 3a and Booth recoding
   assign a_ext = {{2{is_signed & a[WIDTH-1]}}, a};
   assign a3    = a_ext + {a_ext[WIDTH:0], 1'b0};
   assign bx    = {{(BX-WIDTH-1){is_signed & b[WIDTH-1]}}, b, 1'b0};

   for (genvar i = 0; i < PP_N; i++) begin : g_rec
      logic [3:0] grp;
      assign grp    = bx[3*i +: 4];
      assign dig[i] = {3'b0, grp[0]} + {3'b0, grp[1]}
                    + {2'b0, grp[2], 1'b0} - {1'b0, grp[3], 2'b0};
   end

   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         s1_a   <= a_ext;
         s1_a3  <= a3;
         s1_dig <= dig;
         s1_sgn <= is_signed;
         s1_tag <= in_tag;
      end
   end

   // S2: partial products, +1 of each negative digit kept in cor
   assign ax  = {{(P2-WIDTH-2){s1_a[WIDTH+1]}}, s1_a};
   assign a3x = {{(P2-WIDTH-2){s1_sgn & s1_a3[WIDTH+1]}}, s1_a3};

   for (genvar i = 0; i < PP_N; i++) begin : g_pp
      logic          neg;
      logic [2:0]    mag;
      logic [P2-1:0] mul;
      assign neg = s1_dig[i][3];
      assign mag = neg ? (~s1_dig[i][2:0] + 3'd1) : s1_dig[i][2:0];
      always_comb begin
         unique case (mag)
            3'd1:    mul = ax;
            3'd2:    mul = ax << 1;
            3'd3:    mul = a3x;
            3'd4:    mul = ax << 2;
            default: mul = '0;
         endcase
      end
      assign pp[i] = (neg ? ~mul : mul) << (3 * i);
   end

   always_comb begin
      cor = '0;
      for (int i = 0; i < PP_N; i++) cor[3*i] = s1_dig[i][3];
   end

   assign pp[PP_N] = cor;

   // Wallace reduction: each level maps groups of 3 rows to 2
   always_comb begin
      row = pp;
      nxt = '0;
      n   = ROWS;
      g   = 0;
      for (int l = 0; l < ROWS; l++) begin
         if (n > 2) begin
            g   = n / 3;
            nxt = '0;
            for (int j = 0; j < ROWS / 3; j++) begin
               if (j < g) begin
                  nxt[2*j] = row[3*j] ^ row[3*j+1] ^ row[3*j+2];
                  nxt[2*j+1] = ((row[3*j] & row[3*j+1])
                             | (row[3*j] & row[3*j+2])
                             | (row[3*j+1] & row[3*j+2])) << 1;
               end
            end
            for (int r = 0; r < 2; r++) begin
               if (r < n - 3 * g) nxt[2*g+r] = row[3*g+r];
            end
            row = nxt;
            n   = 2 * g + (n - 3 * g);
         end
      end
      sum = row[0];
      car = row[1];
   end

   always_ff @(posedge clk) begin
      if (en && v1) begin
         s2_sum <= sum;
         s2_car <= car;
         s2_sgn <= s1_sgn;
         s2_tag <= s1_tag;
      end
   end

   // S3: carry-propagate resolve and stage valids
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1         <= 1'b0;
         v2         <= 1'b0;
         v3         <= 1'b0;
         out        <= '0;
         out_tag    <= '0;
         out_signed <= 1'b0;
      end else if (en) begin
         v1 <= in_valid;
         v2 <= v1;
         v3 <= v2;
         if (v2) begin
            out        <= s2_sum + s2_car;
            out_tag    <= s2_tag;
            out_signed <= s2_sgn;
         end
      end
   end

endmodule

// File: tb/tb_booth_wallace_mul_pipe.sv
// Bench for booth_wallace_mul_pipe at widths 32, 16 and 13.
// Directed handshake cases on the 32-bit copy, random streams on all.
module tb_booth_wallace_mul_pipe;

   typedef struct packed {
      logic [63:0] p;
      logic [3:0]  t;
      logic        s;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid [3];
   logic        in_ready [3];
   logic [31:0] a [3];
   logic [31:0] b [3];
   logic        sgn [3];
   logic [3:0]  tag [3];
   logic        out_valid [3];
   logic        out_ready [3];
   logic [63:0] o [3];
   logic [3:0]  out_tag [3];
   logic        out_signed [3];

   int   n_tests, n_fail;
   exp_t sb [3][16];
   int   wr [3], rd [3], n_in [3], n_out [3];
   exp_t me;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int W = (k == 0) ? 32 : ((k == 1) ? 16 : 13);
      logic [W-1:0]   da, db;
      logic [2*W-1:0] dout;
      assign da   = a[k][W-1:0];
      assign db   = b[k][W-1:0];
      assign o[k] = 64'(dout);
      booth_wallace_mul_pipe #(.WIDTH(W), .TAG_W(4)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .in_valid   (in_valid[k]),
         .in_ready   (in_ready[k]),
         .a          (da),
         .b          (db),
         .is_signed  (sgn[k]),
         .in_tag     (tag[k]),
         .out_valid  (out_valid[k]),
         .out_ready  (out_ready[k]),
         .out        (dout),
         .out_tag    (out_tag[k]),
         .out_signed (out_signed[k])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wof(int k);
      return (k == 0) ? 32 : ((k == 1) ? 16 : 13);
   endfunction

   // Full-precision product in the chosen mode, reduced to 2*w bits
   function automatic logic [63:0] model(int w, logic [31:0] x,
                                         logic [31:0] y, logic s);
      logic [63:0] xu, yu, p, m;
      longint      xs, ys;
      xu = 64'(x);
      yu = 64'(y);
      if (s) begin
         xs = $signed(xu << (64 - w)) >>> (64 - w);
         ys = $signed(yu << (64 - w)) >>> (64 - w);
         p  = 64'(xs * ys);
      end else begin
         p = xu * yu;
      end
      m = (64'd1 << (2 * w)) - 64'd1;
      return p & m;
   endfunction

   function automatic logic [31:0] pick(int w);
      logic [31:0] m, r;
      m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      case ($urandom % 8)
         0:       r = '0;
         1:       r = 32'd1 << (w - 1);
         2:       r = m;
         3:       r = 32'd1;
         default: r = $urandom & m;
      endcase
      return r;
   endfunction

   task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: transfers are decided at the next rising edge
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            rd[k] = wr[k];
         end else begin
            if (out_valid[k] && out_ready[k]) begin
               if (rd[k] == wr[k]) begin
                  check("extra_out", 64'(out_valid[k]), 64'd0);
               end else begin
                  me = sb[k][rd[k] % 16];
                  check("sb_prod", o[k], me.p);
                  check("sb_tag", 64'(out_tag[k]), 64'(me.t));
                  check("sb_sgn", 64'(out_signed[k]), 64'(me.s));
                  rd[k]++;
                  n_out[k]++;
               end
            end
            if (in_valid[k] && in_ready[k]) begin
               me.p = model(wof(k), a[k], b[k], sgn[k]);
               me.t = tag[k];
               me.s = sgn[k];
               sb[k][wr[k] % 16] = me;
               wr[k]++;
               n_in[k]++;
            end
         end
      end
   end

   task automatic one_shot(string nm, logic [31:0] x, logic [31:0] y,
                           logic s, logic [3:0] t, logic [63:0] ex);
      in_valid[0] = 1'b1;
      a[0] = x;
      b[0] = y;
      sgn[0] = s;
      tag[0] = t;
      step();
      in_valid[0] = 1'b0;
      check({nm, "_lat1"}, 64'(out_valid[0]), 64'd0);
      step();
      check({nm, "_lat2"}, 64'(out_valid[0]), 64'd0);
      step();
      check({nm, "_valid"}, 64'(out_valid[0]), 64'd1);
      check({nm, "_out"}, o[0], ex);
      check({nm, "_tag"}, 64'(out_tag[0]), 64'(t));
      check({nm, "_sgn"}, 64'(out_signed[0]), 64'(s));
      step();
   endtask

   task automatic rand_run(int k, int num);
      int in0, out0, cyc;
      in0  = n_in[k];
      out0 = n_out[k];
      cyc  = 0;
      while (n_in[k] - in0 < num && cyc < 20 * num) begin
         in_valid[k]  = ($urandom % 4) != 0;
         a[k]         = pick(wof(k));
         b[k]         = pick(wof(k));
         sgn[k]       = 1'($urandom % 2);
         tag[k]       = 4'($urandom);
         out_ready[k] = ($urandom % 10) < 7;
         step();
         cyc++;
      end
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      cyc = 0;
      while (rd[k] != wr[k] && cyc < 50) begin
         step();
         cyc++;
      end
      check("rand_accepted", 64'(n_in[k] - in0), 64'(num));
      check("rand_drained", 64'(n_out[k] - out0), 64'(n_in[k] - in0));
   endtask

   logic [31:0] ba [3], bb [3];
   logic        bs [3];
   logic [63:0] held;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int k = 0; k < 3; k++) begin
         in_valid[k]  = 1'b0;
         out_ready[k] = 1'b1;
         a[k] = '0;
         b[k] = '0;
         sgn[k] = 1'b0;
         tag[k] = '0;
         wr[k] = 0;
         rd[k] = 0;
         n_in[k] = 0;
         n_out[k] = 0;
      end
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #10;
      for (int k = 0; k < 3; k++) begin
         check("rst_valid", 64'(out_valid[k]), 64'd0);
         check("rst_out", o[k], 64'd0);
         check("rst_ready", 64'(in_ready[k]), 64'd0);
         check("rst_tag", 64'(out_tag[k]), 64'd0);
      end
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      #1 check("rel_ready", 64'(in_ready[0]), 64'd1);
      step();

      one_shot("u_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd5,
               64'hFFFF_FFFE_0000_0001);
      one_shot("s_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 4'd6,
               64'h4000_0000_0000_0000);
      one_shot("s_m1x3", 32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 4'd7,
               64'hFFFF_FFFF_FFFF_FFFD);

      // Streaming: four back-to-back transfers
      for (int t = 0; t < 4; t++) begin
         in_valid[0] = 1'b1;
         a[0] = $urandom;
         b[0] = $urandom;
         sgn[0] = 1'($urandom % 2);
         tag[0] = 4'(t);
         step();
         if (t == 3) in_valid[0] = 1'b0;
         if (t >= 2) begin
            check("stream_valid", 64'(out_valid[0]), 64'd1);
            check("stream_tag", 64'(out_tag[0]), 64'(t - 2));
         end
      end
      for (int t = 2; t < 4; t++) begin
         step();
         check("stream_valid", 64'(out_valid[0]), 64'd1);
         check("stream_tag", 64'(out_tag[0]), 64'(t));
      end
      step();
      check("stream_end", 64'(out_valid[0]), 64'd0);

      // Backpressure with three results in the pipe
      out_ready[0] = 1'b0;
      for (int t = 0; t < 3; t++) begin
         ba[t] = pick(32);
         bb[t] = pick(32);
         bs[t] = 1'($urandom % 2);
         in_valid[0] = 1'b1;
         a[0] = ba[t];
         b[0] = bb[t];
         sgn[0] = bs[t];
         tag[0] = 4'(8 + t);
         step();
      end
      in_valid[0] = 1'b0;
      check("bp_valid", 64'(out_valid[0]), 64'd1);
      check("bp_out0", o[0], model(32, ba[0], bb[0], bs[0]));
      held = o[0];
      for (int c = 0; c < 5; c++) begin
         check("bp_ready", 64'(in_ready[0]), 64'd0);
         check("bp_hold", o[0], held);
         check("bp_tag", 64'(out_tag[0]), 64'd8);
         step();
      end
      out_ready[0] = 1'b1;
      for (int t = 1; t < 3; t++) begin
         step();
         check("bp_drain_v", 64'(out_valid[0]), 64'd1);
         check("bp_drain_t", 64'(out_tag[0]), 64'(8 + t));
         check("bp_drain_o", o[0], model(32, ba[t], bb[t], bs[t]));
      end
      step();
      check("bp_empty", 64'(out_valid[0]), 64'd0);

      // Reset with two transactions in flight
      for (int t = 0; t < 2; t++) begin
         in_valid[0] = 1'b1;
         a[0] = 32'h1234_5678 + 32'(t);
         b[0] = 32'h0000_0101;
         sgn[0] = 1'b0;
         tag[0] = 4'(12 + t);
         step();
      end
      in_valid[0] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mrst_valid", 64'(out_valid[0]), 64'd0);
      check("mrst_out", o[0], 64'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1 check("mrst_ready", 64'(in_ready[0]), 64'd1);
      for (int c = 0; c < 6; c++) begin
         step();
         check("mrst_quiet", 64'(out_valid[0]), 64'd0);
      end

      rand_run(0, 1000);
      rand_run(1, 300);
      rand_run(2, 300);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
